// File: rtl/pwr_rail_sequencer_if.sv
// -----------------------------------------------------------------------------
// pwr_rail_sequencer_if
// Bundles the power request, the rail enable/power-good pairs and the status
// outputs of the rail sequencer.
//   master : board-level side (drives PwrReq and RailPg, observes status)
//   slave  : the sequencer itself
// Signals:
//   PwrReq    power request level (1 = on)
//   RailPg    per-rail power-good returns
//   RailEn    per-rail regulator enables
//   PwrOk     platform power-ok
//   Fault     sticky fault flag
//   FaultRail index of the offending rail
//   FaultType 0 = PG timeout on power-up, 1 = PG lost on an enabled rail
//   SeqState  encoded sequencer state for debug
// -----------------------------------------------------------------------------
interface pwr_rail_sequencer_if #(
   parameter int NUM_RAILS = 4
);
   logic                 PwrReq;
   logic [NUM_RAILS-1:0] RailPg;
   logic [NUM_RAILS-1:0] RailEn;
   logic                 PwrOk;
   logic                 Fault;
   logic [2:0]           FaultRail;
   logic                 FaultType;
   logic [2:0]           SeqState;

   modport master (
      output PwrReq, RailPg,
      input  RailEn, PwrOk, Fault, FaultRail, FaultType, SeqState
   );

   modport slave (
      input  PwrReq, RailPg,
      output RailEn, PwrOk, Fault, FaultRail, FaultType, SeqState
   );
endinterface

// File: rtl/pwr_rail_sequencer.sv
// -----------------------------------------------------------------------------
// pwr_rail_sequencer
// Powers up NUM_RAILS rails in index order (each gated on the previous rail's
// power-good plus a stagger delay), raises PwrOk after a settle time, and
// powers the rails down in reverse order when the request is withdrawn.
// Power-good timeouts and power-good loss force every rail off at once and
// latch a fault that is held for at least a cool-down period.
// Ports:
//   Clk33K : 33 kHz sequencing clock (all delays in ticks of this clock)
//   Rst    : synchronous active-high reset
//   bus    : pwr_rail_sequencer_if slave modport (request, PG in; enables,
//            PwrOk, fault info and debug state out, all registered)
// -----------------------------------------------------------------------------
module pwr_rail_sequencer #(
   parameter int NUM_RAILS    = 4,
   parameter int T_PG_TIMEOUT = 334,
   parameter int T_STAGGER    = 34,
   parameter int T_PWROK      = 3334,
   parameter int T_DOWN       = 34,
   parameter int T_COOL       = 6667
) (
   input logic                  Clk33K,
   input logic                  Rst,
   pwr_rail_sequencer_if.slave  bus
);

   localparam int IDX_W = $clog2(NUM_RAILS);

   localparam logic [31:0]      PG_LAST    = 32'(T_PG_TIMEOUT - 1);
   localparam logic [31:0]      STAG_LAST  = 32'(T_STAGGER - 1);
   localparam logic [31:0]      PWROK_LAST = 32'(T_PWROK - 1);
   localparam logic [31:0]      DOWN_LAST  = 32'(T_DOWN - 1);
   localparam logic [31:0]      COOL_LAST  = 32'(T_COOL - 1);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_RAILS - 1);

   typedef enum logic [2:0] {
      ST_OFF        = 3'd0,
      ST_UP_WAITPG  = 3'd1,
      ST_UP_STAGGER = 3'd2,
      ST_UP_PWROK   = 3'd3,
      ST_ON         = 3'd4,
      ST_DOWN       = 3'd5,
      ST_FAULT      = 3'd6
   } state_t;

   state_t               state_r, state_nxt_s;
   logic [IDX_W-1:0]     idx_r, idx_nxt_s;
   logic [31:0]          cnt_r;
   logic                 cnt_clr_s;
   logic [NUM_RAILS-1:0] rail_en_r, rail_en_nxt_s;
   logic                 pwr_ok_r, pwr_ok_nxt_s;
   logic                 fault_r, fault_nxt_s;
   logic [2:0]           fault_rail_r, fault_rail_nxt_s;
   logic                 fault_type_r, fault_type_nxt_s;

   logic [NUM_RAILS-1:0] mon_mask_s;
   logic [NUM_RAILS-1:0] drop_vec_s;
   logic                 drop_any_s;
   logic [IDX_W-1:0]     drop_idx_s;

   // Rails 0..n inclusive: the enable mask while rail n is being brought up.
   function automatic logic [NUM_RAILS-1:0] up_mask(input logic [IDX_W-1:0] n);
      logic [NUM_RAILS-1:0] m;
      for (int k = 0; k < NUM_RAILS; k++) begin
         m[k] = (k <= int'(n));
      end
      return m;
   endfunction

   // Rails strictly below n: the rails already confirmed good during power-up.
   function automatic logic [NUM_RAILS-1:0] low_mask(input logic [IDX_W-1:0] n);
      logic [NUM_RAILS-1:0] m;
      for (int k = 0; k < NUM_RAILS; k++) begin
         m[k] = (k < int'(n));
      end
      return m;
   endfunction

   // Drop monitor: find the lowest monitored rail whose power-good is low.
   always_comb begin
      case (state_r)
         ST_UP_WAITPG, ST_UP_STAGGER: mon_mask_s = low_mask(idx_r);
         ST_UP_PWROK, ST_ON:          mon_mask_s = '1;
         default:                     mon_mask_s = '0;
      endcase
      drop_vec_s = mon_mask_s & ~bus.RailPg;
      drop_any_s = |drop_vec_s;
      drop_idx_s = '0;
      // Descending scan so the lowest failing index wins.
      for (int j = NUM_RAILS - 1; j >= 0; j--) begin
         drop_idx_s = drop_vec_s[j] ? IDX_W'(j) : drop_idx_s;
      end
   end

   // State, rail pointer, tick counter and registered outputs.
   always_ff @(posedge Clk33K) begin
      if (Rst) begin
         state_r      <= ST_OFF;
         idx_r        <= '0;
         cnt_r        <= 32'd0;
         rail_en_r    <= '0;
         pwr_ok_r     <= 1'b0;
         fault_r      <= 1'b0;
         fault_rail_r <= 3'd0;
         fault_type_r <= 1'b0;
      end else begin
         state_r      <= state_nxt_s;
         idx_r        <= idx_nxt_s;
         rail_en_r    <= rail_en_nxt_s;
         pwr_ok_r     <= pwr_ok_nxt_s;
         fault_r      <= fault_nxt_s;
         fault_rail_r <= fault_rail_nxt_s;
         fault_type_r <= fault_type_nxt_s;
         // Saturating tick counter.
         if (cnt_clr_s) begin
            cnt_r <= 32'd0;
         end else if (cnt_r != 32'hFFFF_FFFF) begin
            cnt_r <= cnt_r + 32'd1;
         end
      end
   end

   // Next-state logic; priority is drop fault > timeout > request withdrawn > progress.
   always_comb begin
      state_nxt_s = state_r;
      idx_nxt_s   = idx_r;
      case (state_r)
         ST_OFF: begin
            if (bus.PwrReq) begin
               state_nxt_s = ST_UP_WAITPG;
               idx_nxt_s   = '0;
            end else begin
               state_nxt_s = ST_OFF;
            end
         end
         ST_UP_WAITPG: begin
            if (drop_any_s) begin
               state_nxt_s = ST_FAULT;
            end else if (!bus.RailPg[idx_r] && (cnt_r >= PG_LAST)) begin
               state_nxt_s = ST_FAULT;
            end else if (!bus.PwrReq) begin
               state_nxt_s = ST_DOWN;
            end else if (bus.RailPg[idx_r]) begin
               state_nxt_s = (idx_r == IDX_LAST) ? ST_UP_PWROK : ST_UP_STAGGER;
            end else begin
               state_nxt_s = ST_UP_WAITPG;
            end
         end
         ST_UP_STAGGER: begin
            if (drop_any_s) begin
               state_nxt_s = ST_FAULT;
            end else if (!bus.PwrReq) begin
               state_nxt_s = ST_DOWN;
            end else if (cnt_r >= STAG_LAST) begin
               state_nxt_s = ST_UP_WAITPG;
               idx_nxt_s   = idx_r + IDX_W'(1);
            end else begin
               state_nxt_s = ST_UP_STAGGER;
            end
         end
         ST_UP_PWROK: begin
            if (drop_any_s) begin
               state_nxt_s = ST_FAULT;
            end else if (!bus.PwrReq) begin
               state_nxt_s = ST_DOWN;
            end else if (cnt_r >= PWROK_LAST) begin
               state_nxt_s = ST_ON;
            end else begin
               state_nxt_s = ST_UP_PWROK;
            end
         end
         ST_ON: begin
            if (drop_any_s) begin
               state_nxt_s = ST_FAULT;
            end else if (!bus.PwrReq) begin
               state_nxt_s = ST_DOWN;
            end else begin
               state_nxt_s = ST_ON;
            end
         end
         ST_DOWN: begin
            // PG and request are deliberately ignored until every rail is off.
            if (rail_en_r == '0) begin
               state_nxt_s = ST_OFF;
            end else begin
               state_nxt_s = ST_DOWN;
            end
         end
         ST_FAULT: begin
            if ((cnt_r >= COOL_LAST) && !bus.PwrReq) begin
               state_nxt_s = ST_OFF;
            end else begin
               state_nxt_s = ST_FAULT;
            end
         end
         default: begin
            state_nxt_s = ST_OFF;
            idx_nxt_s   = '0;
         end
      endcase
   end

   // Next values of the registered outputs and the counter clear.
   always_comb begin
      rail_en_nxt_s    = rail_en_r;
      pwr_ok_nxt_s     = pwr_ok_r;
      fault_nxt_s      = fault_r;
      fault_rail_nxt_s = fault_rail_r;
      fault_type_nxt_s = fault_type_r;
      cnt_clr_s        = (state_nxt_s != state_r) || (idx_nxt_s != idx_r) ||
                         ((state_r == ST_DOWN) && (cnt_r >= DOWN_LAST));
      case (state_nxt_s)
         ST_OFF: begin
            rail_en_nxt_s = '0;
            pwr_ok_nxt_s  = 1'b0;
            fault_nxt_s   = 1'b0;
         end
         ST_UP_WAITPG, ST_UP_STAGGER, ST_UP_PWROK: begin
            rail_en_nxt_s = up_mask(idx_nxt_s);
            pwr_ok_nxt_s  = 1'b0;
         end
         ST_ON: begin
            rail_en_nxt_s = '1;
            pwr_ok_nxt_s  = 1'b1;
         end
         ST_DOWN: begin
            pwr_ok_nxt_s = 1'b0;
            // Mask is contiguous from bit 0, so a right shift drops the highest rail.
            if (state_r != ST_DOWN) begin
               rail_en_nxt_s = rail_en_r >> 1;
            end else if (cnt_r >= DOWN_LAST) begin
               rail_en_nxt_s = rail_en_r >> 1;
            end else begin
               rail_en_nxt_s = rail_en_r;
            end
         end
         ST_FAULT: begin
            rail_en_nxt_s = '0;
            pwr_ok_nxt_s  = 1'b0;
            fault_nxt_s   = 1'b1;
            // Capture the cause only on the entry edge.
            if (state_r != ST_FAULT) begin
               fault_rail_nxt_s = drop_any_s ? 3'(drop_idx_s) : 3'(idx_r);
               fault_type_nxt_s = drop_any_s;
            end else begin
               fault_rail_nxt_s = fault_rail_r;
               fault_type_nxt_s = fault_type_r;
            end
         end
         default: begin
            rail_en_nxt_s = '0;
            pwr_ok_nxt_s  = 1'b0;
         end
      endcase
   end

   assign bus.RailEn    = rail_en_r;
   assign bus.PwrOk     = pwr_ok_r;
   assign bus.Fault     = fault_r;
   assign bus.FaultRail = fault_rail_r;
   assign bus.FaultType = fault_type_r;
   assign bus.SeqState  = state_r;

endmodule
